// File: rtl/pn_token_if.sv
// Token/result link between the PN transmit block and the PN evaluator.
// The master drives tokens toward the evaluator; the slave returns result beats.
interface pn_token_if;
   logic [1:0]         pn_mode;
   logic               pn_operator;
   logic [2:0]         pn_in;
   logic               pn_in_valid;
   logic               pn_out_valid;
   logic signed [31:0] pn_out;

   modport master (
      output pn_mode, pn_operator, pn_in, pn_in_valid,
      input  pn_out_valid, pn_out
   );

   modport slave (
      input  pn_mode, pn_operator, pn_in, pn_in_valid,
      output pn_out_valid, pn_out
   );
endinterface

// File: rtl/pn_token_tx.sv
// Buffers host-loaded PN tokens, bursts them to the evaluator on start and
// collects up to four result beats, with timeout and protocol-fault reporting.
//
// state  | meaning
// IDLE   | accept token loads, wait for start
// SEND   | stream tok_buf[0..tok_cnt-1], one beat per cycle
// WAIT   | capture result beats until exp_cnt seen or timer expires
// DONE   | results readable until clear
module pn_token_tx #(
   parameter int MAX_TOK = 12,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ld_valid,
   input  logic               ld_op,
   input  logic [2:0]         ld_val,
   input  logic [1:0]         ld_mode,
   input  logic               start,
   input  logic               clear,
   output logic [3:0]         tok_cnt,
   output logic               busy,
   pn_token_if.master         ev,
   input  logic [1:0]         res_idx,
   output logic signed [31:0] res_data,
   output logic [2:0]         res_cnt,
   output logic               done,
   output logic               err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [3:0]         tok_buf [MAX_TOK];
   logic signed [31:0] result [4];
   logic [3:0]         send_idx;
   logic [2:0]         exp_cnt;
   logic [1:0]         mode_r;
   logic [TW-1:0]      timer;

   logic do_load, do_start, do_clear, ld_drop, beat, last_beat, res_store, tmo, fault;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      do_load   = 1'b0;
      do_start  = 1'b0;
      do_clear  = 1'b0;
      ld_drop   = 1'b0;
      beat      = 1'b0;
      last_beat = 1'b0;
      res_store = 1'b0;
      tmo       = 1'b0;
      fault     = ev.pn_out_valid && (state != S_WAIT);
      case (state)
         S_IDLE: begin
            // start takes priority over a same-cycle load, which is dropped silently
            if (clear) begin
               do_clear = 1'b1;
            end else if (start) begin
               if (tok_cnt != 4'd0) begin
                  do_start  = 1'b1;
                  state_nxt = S_SEND;
               end
            end else if (ld_valid) begin
               if (tok_cnt < 4'(MAX_TOK)) do_load = 1'b1;
               else                       ld_drop = 1'b1;
            end
         end
         S_SEND: begin
            if (send_idx == tok_cnt) begin
               last_beat = 1'b1;
               state_nxt = (exp_cnt == 3'd0) ? S_DONE : S_WAIT;
            end else begin
               beat = 1'b1;
            end
         end
         S_WAIT: begin
            res_store = ev.pn_out_valid;
            if (ev.pn_out_valid && (res_cnt + 3'd1 == exp_cnt)) begin
               state_nxt = S_DONE;
            end else if (timer == '0) begin
               tmo       = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (clear) begin
               do_clear  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_load) tok_buf[tok_cnt] <= {ld_op, ld_val};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok_cnt        <= '0;
         res_cnt        <= '0;
         err            <= 1'b0;
         timer          <= '0;
         send_idx       <= '0;
         exp_cnt        <= '0;
         mode_r         <= '0;
         ev.pn_in_valid <= 1'b0;
         ev.pn_mode     <= '0;
         ev.pn_operator <= 1'b0;
         ev.pn_in       <= '0;
         for (int i = 0; i < 4; i++) result[i] <= '0;
      end else begin
         if (do_clear) begin
            tok_cnt <= '0;
            res_cnt <= '0;
            err     <= 1'b0;
            timer   <= '0;
         end
         if (do_load) tok_cnt <= tok_cnt + 4'd1;
         if (do_start) begin
            mode_r         <= ld_mode;
            exp_cnt        <= (ld_mode < 2'd2) ? 3'(tok_cnt / 4'd3) : 3'd1;
            res_cnt        <= '0;
            send_idx       <= 4'd1;
            ev.pn_in_valid <= 1'b1;
            ev.pn_mode     <= ld_mode;
            ev.pn_operator <= tok_buf[0][3];
            ev.pn_in       <= tok_buf[0][2:0];
         end else if (beat) begin
            send_idx       <= send_idx + 4'd1;
            ev.pn_in_valid <= 1'b1;
            ev.pn_mode     <= mode_r;
            ev.pn_operator <= tok_buf[send_idx][3];
            ev.pn_in       <= tok_buf[send_idx][2:0];
         end else begin
            ev.pn_in_valid <= 1'b0;
            ev.pn_mode     <= '0;
            ev.pn_operator <= 1'b0;
            ev.pn_in       <= '0;
         end
         // WAIT lasts exactly TIMEOUT cycles when no completion arrives
         if (last_beat)
            timer <= TW'(TIMEOUT - 1);
         else if (state == S_WAIT && timer != '0)
            timer <= timer - 1'b1;
         if (res_store) begin
            result[res_cnt[1:0]] <= ev.pn_out;
            res_cnt              <= res_cnt + 3'd1;
         end
         if (ld_drop || tmo || fault) err <= 1'b1;
      end
   end

   assign busy     = (state == S_SEND) || (state == S_WAIT);
   assign done     = (state == S_DONE);
   assign res_data = result[res_idx];

endmodule

// File: doc/pn_token_tx.md
# pn_token_tx

Stimulus and transmit block for the Polish Notation (PN) evaluator. A host loads up to MAX_TOK tokens and a mode into it. On `start` it drives them onto the evaluator's token input as one contiguous `in_valid` burst. It then collects the evaluator's `out_valid`/`out` result beats into a 4-entry result buffer, and reports `done` (plus `err` on timeout or protocol fault). It sits on the evaluator's input side and is used both as an on-chip driver and as a self-checking bench front end.

## Interface
- MAX_TOK, 12, token buffer depth; fixed to the evaluator's maximum expression length
- TIMEOUT, 1024, maximum WAIT cycles before abandoning a transaction
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ld_valid  in  1  push one token into the buffer
- ld_op  in  1  token kind: 1 = operator, 0 = operand
- ld_val  in  3  token value (operator code 0..3: +, -, *, |a+b|; or operand 0..7)
- ld_mode  in  2  mode, sampled on `start`
- start  in  1  begin transmission
- clear  in  1  return from DONE to IDLE
- tok_cnt  out  4  number of tokens loaded
- busy  out  1  high in SEND and WAIT
- pn_mode  out  2  to evaluator `mode`
- pn_operator  out  1  to evaluator `operator`
- pn_in  out  3  to evaluator `in`
- pn_in_valid  out  1  to evaluator `in_valid`
- pn_out_valid  in  1  from evaluator `out_valid`
- pn_out  in  32  signed, from evaluator `out`
- res_idx  in  2  result read index
- res_data  out  32  signed; combinational read of result[res_idx]
- res_cnt  out  3  number of results captured
- done  out  1  high in DONE
- err  out  1  sticky error flag, cleared by `clear`

## Operation
- States: IDLE, SEND, WAIT, DONE.
- IDLE, loading:
  - `ld_valid` with tok_cnt < MAX_TOK writes {ld_op, ld_val} to buf[tok_cnt] and increments tok_cnt.
  - `ld_valid` with tok_cnt == MAX_TOK drops the token and sets err.
- IDLE, starting:
  - `start` with tok_cnt ≥ 1 latches ld_mode into mode_r and computes exp_cnt = (mode_r < 2) ? tok_cnt/3 (integer division) : 1.
  - It also clears res_cnt and moves to SEND.
  - `start` with tok_cnt == 0 is ignored.
  - `start` and `ld_valid` in the same cycle: start wins, the token is dropped, err is unchanged.
- SEND:
  - Emits buf[0..tok_cnt-1] in index order, one per cycle, with pn_in_valid = 1.
  - pn_mode = mode_r is held for every beat.
  - After the last beat, goes to WAIT, or directly to DONE if exp_cnt == 0.
- WAIT:
  - Each cycle with pn_out_valid = 1 stores pn_out into result[res_cnt] and increments res_cnt.
  - When res_cnt reaches exp_cnt, goes to DONE.
  - The wait timer counts cycles; when it reaches TIMEOUT, goes to DONE with err = 1.
- DONE:
  - done = 1; results are readable.
  - `clear` returns to IDLE and zeroes tok_cnt, res_cnt, err, and the timer. Buffer contents need not be zeroed.
  - `start` and `ld_valid` in DONE are ignored.
- pn_out_valid in IDLE, SEND, or DONE is a protocol fault: the beat is not stored and err is set.
- `ld_valid` and `start` are ignored in SEND and WAIT.
- All pn_* outputs are registered. When pn_in_valid = 0, pn_mode, pn_operator and pn_in are driven to 0.

## Timing
- Reset (asynchronous, any state): state = IDLE. Every output is 0: tok_cnt, busy, pn_mode, pn_operator, pn_in, pn_in_valid, res_data, res_cnt, done, err. The result buffer is zeroed.
- `start` sampled at edge k with N tokens:
  - pn_in_valid is high from cycle k+1 through cycle k+N inclusive.
  - busy is high from cycle k+1.
  - pn_in_valid is guaranteed low in cycle k+N+1. The evaluator needs this gap to leave its receive state.
- WAIT begins at cycle k+N+1.
- A result beat sampled at edge m is visible on res_data/res_cnt from cycle m+1.
- The final beat moves state to DONE at the same edge, so done is high from cycle m+1.
- Timeout: if no completion occurs, done and err rise exactly TIMEOUT cycles after WAIT entry.
- Reset asserted mid-SEND drops pn_in_valid to 0 immediately, without waiting for a clock edge.

## Test plan
- Mode 0, 6 tokens: (op 2)(3)(4)(op 0)(1)(2). Expect 6 beats with pn_mode = 0. Responder returns 12 then 3 → res_cnt = 2, result[0] = 12, result[1] = 3, done = 1, err = 0.
- Mode 3 postfix: 3 4 (op 0) 2 (op 2). Expect 5 beats with pn_in_valid low on the 6th cycle. Responder returns 14 → res_cnt = 1, res_data(0) = 14.
- TIMEOUT = 16, mode 2, responder silent → done and err both rise exactly 16 cycles after WAIT entry; res_cnt = 0.
- 13 consecutive `ld_valid` pulses → tok_cnt = 12, err = 1. Then `clear` → tok_cnt = 0, err = 0.
- `start` with an empty buffer → state stays IDLE, busy = 0. Then stray pn_out_valid in IDLE → err = 1 and res_cnt stays 0.
- rst_n pulled low during the 3rd SEND beat → pn_in_valid = 0 before the next edge. After release, all outputs are 0 and `start` is accepted only after reloading tokens.
